// File: rtl/hs_rx_sink_pkg.sv
// Shared types and default sizes for the handshake receive sink.
package hs_rx_sink_pkg;

  // Receive handshake states: waiting for a word, or holding ack until valid drops.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } rx_state_e;

  localparam int DW_DEFAULT = 4;
  localparam int AW_DEFAULT = 2;
  localparam int CW_DEFAULT = 16;

endpackage

// File: rtl/hs_rx_sink_sync_2ff.sv
// Single-bit two-flop synchroniser; the second flop is the only usable output.
module hs_rx_sink_sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_reg;
  logic sync_reg;

  // Two back-to-back flops with nothing in between to give metastability time to settle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d_i;
      sync_reg <= meta_reg;
    end
  end

  assign q_o = sync_reg;

endmodule

// File: rtl/hs_rx_sink.sv
// Consumer side of the port's 4-phase handshake: synchronises valid, captures the
// word into a small first-word-fall-through FIFO, and streams it out valid/ready.
module hs_rx_sink
  import hs_rx_sink_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          validrx_i,
  input  logic [DW-1:0] dat_i,
  output logic          ackrx_o,
  output logic [DW-1:0] dat_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic [CW-1:0] xfer_cnt_o
);

  localparam int DEPTH = 2 ** AW;

  logic          vld_s;
  rx_state_e     state_reg;
  logic          ack_reg;
  logic [CW-1:0] xfer_reg;
  logic [AW:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          full_reg, full_next;
  logic          empty_reg, empty_next;
  logic          push;
  logic          pop;
  logic [DW-1:0] mem [DEPTH];

  hs_rx_sink_sync_2ff u_sync_valid (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (validrx_i),
    .q_o    (vld_s)
  );

  // Push uses the registered full flag, so a pop in the same cycle delays the push by one.
  assign push = (state_reg == S_IDLE) && vld_s && !full_reg;
  assign pop  = !empty_reg && ready_i;

  // Handshake FSM: one push per valid-high phase, ack held until valid is seen low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_IDLE;
      ack_reg   <= 1'b0;
      xfer_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (push) begin
            state_reg <= S_ACK;
            ack_reg   <= 1'b1;
            xfer_reg  <= xfer_reg + CW'(1);
          end
        end
        S_ACK: begin
          if (!vld_s) begin
            state_reg <= S_IDLE;
            ack_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          ack_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Next pointer values and the status flags derived from them.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push) wr_ptr_next = wr_ptr_reg + (AW + 1)'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + (AW + 1)'(1);
    count_next = wr_ptr_next - rd_ptr_next;
    empty_next = (wr_ptr_next == rd_ptr_next);
    full_next  = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                 (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
  end

  // Pointers and flags are registered together so they always agree after an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      empty_reg  <= empty_next;
      full_reg   <= full_next;
    end
  end

  // Storage write; dat_i is stable while valid is high so it is captured directly.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= dat_i;
  end

  assign dat_o      = mem[rd_ptr_reg[AW-1:0]];
  assign ackrx_o    = ack_reg;
  assign valid_o    = !empty_reg;
  assign full_o     = full_reg;
  assign empty_o    = empty_reg;
  assign count_o    = count_reg;
  assign xfer_cnt_o = xfer_reg;

endmodule

// File: tb/tb_hs_rx_sink.sv
// Self-checking bench for hs_rx_sink: a queue-based model of sent, buffered and
// popped words is compared against the DUT on every falling clock edge.
module tb_hs_rx_sink;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int CW = 16;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          sclk = 1'b0;
  logic          rst_ni;
  logic          validrx_i;
  logic [DW-1:0] dat_i;
  logic          ackrx_o;
  logic [DW-1:0] dat_o;
  logic          valid_o;
  logic          ready_i;
  logic          full_o;
  logic          empty_o;
  logic [AW:0]   count_o;
  logic [CW-1:0] xfer_cnt_o;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [DW-1:0] sent_q[$];
  logic [DW-1:0] mfifo[$];
  logic [DW-1:0] pop_log[$];
  int            xfers = 0;
  logic          prev_ack = 1'b0;
  logic          prev_pop = 1'b0;
  logic          rand_mode = 1'b0;
  logic          ready_ctl = 1'b0;

  always #5 clk_i = ~clk_i;
  always #7 sclk  = ~sclk;

  hs_rx_sink #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .validrx_i  (validrx_i),
    .dat_i      (dat_i),
    .ackrx_o    (ackrx_o),
    .dat_o      (dat_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .xfer_cnt_o (xfer_cnt_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: advance the model by what happened at the last rising edge, then check.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      check("rst_ack", ackrx_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_empty", empty_o, 1);
      check("rst_full", full_o, 0);
      check("rst_count", count_o, 0);
      check("rst_xfer", xfer_cnt_o, 0);
      mfifo.delete();
      xfers = 0;
      prev_ack = 1'b0;
      prev_pop = 1'b0;
    end else begin
      if (prev_pop && mfifo.size() > 0) void'(mfifo.pop_front());
      if (ackrx_o && !prev_ack) begin
        xfers++;
        checks++;
        if (sent_q.size() == 0) begin
          errors++;
          $display("FAIL dup_push got push with no word outstanding expected none at %0t", $time);
        end else begin
          mfifo.push_back(sent_q.pop_front());
        end
      end
      prev_ack = ackrx_o;
      check("count", count_o, mfifo.size());
      check("full", full_o, mfifo.size() == DEPTH);
      check("empty", empty_o, mfifo.size() == 0);
      check("valid", valid_o, mfifo.size() != 0);
      check("xfer", xfer_cnt_o, xfers % (1 << CW));
      if (valid_o && mfifo.size() > 0) check("dat", dat_o, mfifo[0]);
    end
    ready_i = rand_mode ? 1'($urandom_range(0, 1)) : ready_ctl;
    prev_pop = rst_ni && valid_o && ready_i;
    if (prev_pop) pop_log.push_back(dat_o);
  end

  task automatic wait_ack(input logic v);
    int n = 0;
    while (ackrx_o !== v && n < 300) begin
      @(posedge sclk);
      n++;
    end
    if (ackrx_o !== v) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout got %0b expected %0b at %0t", ackrx_o, v, $time);
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (empty_o !== 1'b1 && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("drain_timeout", empty_o, 1);
  endtask

  // Sender-domain 4-phase transfer of one word.
  task automatic send_word(input logic [DW-1:0] d);
    @(posedge sclk);
    wait_ack(1'b0);
    dat_i = d;
    validrx_i = 1'b1;
    sent_q.push_back(d);
    wait_ack(1'b1);
    validrx_i = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    validrx_i = 1'b0;
    sent_q.delete();
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
  endtask

  initial begin
    int n;
    rst_ni = 1'b0;
    validrx_i = 1'b1;
    dat_i = '0;
    ready_i = 1'b0;

    // 1. reset with valid held high
    repeat (3) @(posedge clk_i);
    #1;
    check("t1_ack", ackrx_o, 0);
    check("t1_valid", valid_o, 0);
    check("t1_empty", empty_o, 1);
    check("t1_count", count_o, 0);
    check("t1_xfer", xfer_cnt_o, 0);
    validrx_i = 1'b0;
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);

    // 2. single word latency
    @(negedge clk_i);
    dat_i = 4'hA;
    validrx_i = 1'b1;
    sent_q.push_back(4'hA);
    repeat (2) @(posedge clk_i);
    #1 check("t2_ack_early", ackrx_o, 0);
    @(posedge clk_i);
    #1;
    check("t2_ack", ackrx_o, 1);
    check("t2_valid", valid_o, 1);
    check("t2_dat", dat_o, 4'hA);
    @(negedge clk_i);
    validrx_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 check("t2_ack_hold", ackrx_o, 1);
    @(posedge clk_i);
    #1;
    check("t2_ack_fall", ackrx_o, 0);
    check("t2_xfer", xfer_cnt_o, 1);
    ready_ctl = 1'b1;
    wait_empty();
    ready_ctl = 1'b0;
    check("t2_popped", pop_log.size() == 1 ? pop_log[0] : 32'hFFFF, 4'hA);
    pop_log.delete();

    // 3. fill the FIFO, stall the fifth word, then drain in order
    for (int i = 1; i <= 4; i++) send_word(4'(i));
    repeat (2) @(posedge clk_i);
    #1;
    check("t3_full", full_o, 1);
    check("t3_count", count_o, 4);
    @(posedge sclk);
    dat_i = 4'h5;
    validrx_i = 1'b1;
    sent_q.push_back(4'h5);
    repeat (20) @(posedge clk_i);
    #1;
    check("t3_stall_ack", ackrx_o, 0);
    check("t3_stall_count", count_o, 4);
    ready_ctl = 1'b1;
    wait_ack(1'b1);
    validrx_i = 1'b0;
    wait_ack(1'b0);
    wait_empty();
    ready_ctl = 1'b0;
    check("t3_pop_n", pop_log.size(), 5);
    for (int i = 0; i < 5; i++)
      check("t3_order", i < pop_log.size() ? pop_log[i] : 32'hFFFF, i + 1);
    check("t3_xfer", xfer_cnt_o, 6);
    pop_log.delete();

    // 5. reset while in ACK
    @(negedge clk_i);
    dat_i = 4'h7;
    validrx_i = 1'b1;
    sent_q.push_back(4'h7);
    n = 0;
    while (ackrx_o !== 1'b1 && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("t5_in_ack", ackrx_o, 1);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("t5_async_ack", ackrx_o, 0);
    check("t5_empty", empty_o, 1);
    check("t5_count", count_o, 0);
    validrx_i = 1'b0;
    sent_q.delete();
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    pop_log.delete();
    send_word(4'h3);
    ready_ctl = 1'b1;
    wait_empty();
    ready_ctl = 1'b0;
    check("t5_xfer", xfer_cnt_o, 1);
    check("t5_word", pop_log.size() == 1 ? pop_log[0] : 32'hFFFF, 4'h3);

    // 6. random traffic with random downstream ready
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge sclk);
      send_word(4'($urandom_range(0, 15)));
    end
    rand_mode = 1'b0;
    ready_ctl = 1'b1;
    wait_empty();
    repeat (2) @(posedge clk_i);
    #1;
    check("t6_xfer", xfer_cnt_o, 500);
    check("t6_outstanding", sent_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
